// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter: round-robin sharing of one i2c_master between register-access clients
module i2c_reg_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 27_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [7*NUM_REQ-1:0] req_dev,
  input  logic [8*NUM_REQ-1:0] req_reg,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic [6:0]           cmd_address,
  output logic                 cmd_start,
  output logic                 cmd_read,
  output logic                 cmd_write,
  output logic                 cmd_write_multiple,
  output logic                 cmd_stop,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           data_tdata,
  output logic                 data_tvalid,
  output logic                 data_tlast,
  input  logic                 data_tready,
  input  logic [7:0]           rx_tdata,
  input  logic                 rx_tvalid,
  output logic                 rx_tready,
  input  logic                 i2c_busy
);
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [3:0] {IDLE, ACC, CMD_W, DREG, DVAL, CMD_R, WAIT_RX, DONE, DRAIN} state_t;
  typedef struct packed {
    state_t             st;
    logic [NUM_REQ-1:0] req_ready;
    logic               rsp_valid;
    logic [2:0]         rsp_id;
    logic [7:0]         rsp_rdata;
    logic               rsp_err;
    logic [6:0]         cmd_address;
    logic               cmd_start;
    logic               cmd_read;
    logic               cmd_write;
    logic               cmd_write_multiple;
    logic               cmd_stop;
    logic               cmd_valid;
    logic [7:0]         data_tdata;
    logic               data_tvalid;
    logic               data_tlast;
    logic [2:0]         cid;
    logic [6:0]         dev;
    logic [7:0]         rg;
    logic [7:0]         wdat;
    logic               wr;
    logic [2:0]         rp;
    logic [WD_W-1:0]    wd;
  } regs_t;
  regs_t r, n;
  logic       hit;
  logic [2:0] g;
  logic [6:0] dev_s;
  logic [7:0] reg_s, wd_s;
  logic       wr_s;
  // choose the first requester at or after the rotation pointer, wrapping to the lowest
  always_comb begin
    hit = |req_valid;
    g = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (req_valid[k]) g = 3'(k);
    for (int k = NUM_REQ - 1; k >= 0; k--) if (req_valid[k] && 3'(k) >= r.rp) g = 3'(k);
    dev_s = '0;
    reg_s = '0;
    wd_s = '0;
    wr_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      if (g == 3'(k)) begin
        dev_s = req_dev[7*k +: 7];
        reg_s = req_reg[8*k +: 8];
        wd_s = req_wdata[8*k +: 8];
        wr_s = req_write[k];
      end
  end
  // sequencer: expands the latched request into i2c_master beats, every output registered
  always_comb begin
    n = r;
    n.req_ready = '0;
    n.rsp_valid = 1'b0;
    n.wd = (r.st == IDLE) ? '0 : r.wd + 1'b1;
    case (r.st)
      IDLE: if (hit) begin
        for (int k = 0; k < NUM_REQ; k++) n.req_ready[k] = (g == 3'(k));
        n.cid = g;
        n.dev = dev_s;
        n.rg = reg_s;
        n.wdat = wd_s;
        n.wr = wr_s;
        n.rp = (g == 3'(NUM_REQ - 1)) ? 3'd0 : g + 3'd1;
        n.st = ACC;
      end
      ACC: begin
        n.cmd_valid = 1'b1;
        n.cmd_address = r.dev;
        n.cmd_start = 1'b1;
        n.cmd_read = 1'b0;
        n.cmd_write = ~r.wr;
        n.cmd_write_multiple = r.wr;
        n.cmd_stop = r.wr;
        n.st = CMD_W;
      end
      CMD_W: if (cmd_ready) begin
        n.cmd_valid = 1'b0;
        n.data_tvalid = 1'b1;
        n.data_tdata = r.rg;
        n.data_tlast = ~r.wr;
        n.st = DREG;
      end
      DREG: if (data_tready) begin
        n.data_tvalid = r.wr;
        n.data_tdata = r.wr ? r.wdat : r.data_tdata;
        n.data_tlast = 1'b1;
        n.cmd_valid = ~r.wr;
        n.cmd_read = ~r.wr;
        n.cmd_write = 1'b0;
        n.cmd_write_multiple = 1'b0;
        n.cmd_stop = 1'b1;
        n.st = r.wr ? DVAL : CMD_R;
      end
      DVAL: if (data_tready) begin
        n.data_tvalid = 1'b0;
        n.rsp_valid = 1'b1;
        n.rsp_id = r.cid;
        n.rsp_rdata = '0;
        n.rsp_err = 1'b0;
        n.st = DONE;
      end
      CMD_R: if (cmd_ready) begin
        n.cmd_valid = 1'b0;
        n.st = WAIT_RX;
      end
      WAIT_RX: if (rx_tvalid) begin
        n.rsp_valid = 1'b1;
        n.rsp_id = r.cid;
        n.rsp_rdata = rx_tdata;
        n.rsp_err = 1'b0;
        n.st = DONE;
      end
      DONE, DRAIN: if (!i2c_busy) n.st = IDLE;
      default: n.st = IDLE;
    endcase
    if ((r.st inside {ACC, CMD_W, DREG, DVAL, CMD_R, WAIT_RX}) && r.wd == WD_W'(TIMEOUT_CYCLES - 2)) begin
      n.cmd_valid = 1'b0;
      n.data_tvalid = 1'b0;
      n.rsp_valid = 1'b1;
      n.rsp_id = r.cid;
      n.rsp_rdata = '0;
      n.rsp_err = 1'b1;
      n.st = DRAIN;
    end
  end
  // state and output register
  always_ff @(posedge clk) begin
    if (rst) r <= '0;
    else r <= n;
  end
  assign req_ready = r.req_ready;
  assign rsp_valid = r.rsp_valid;
  assign rsp_id = r.rsp_id;
  assign rsp_rdata = r.rsp_rdata;
  assign rsp_err = r.rsp_err;
  assign cmd_address = r.cmd_address;
  assign cmd_start = r.cmd_start;
  assign cmd_read = r.cmd_read;
  assign cmd_write = r.cmd_write;
  assign cmd_write_multiple = r.cmd_write_multiple;
  assign cmd_stop = r.cmd_stop;
  assign cmd_valid = r.cmd_valid;
  assign data_tdata = r.data_tdata;
  assign data_tvalid = r.data_tvalid;
  assign data_tlast = r.data_tlast;
  assign rx_tready = 1'b1;
endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// tb_i2c_reg_arbiter: directed vectors plus backpressure, fairness, timeout and reset sequences
module tb_i2c_reg_arbiter;
  localparam int N = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_write = '0, req_ready;
  logic [7*N-1:0] req_dev = '0;
  logic [8*N-1:0] req_reg = '0, req_wdata = '0;
  logic rsp_valid, rsp_err;
  logic [2:0] rsp_id;
  logic [7:0] rsp_rdata;
  logic [6:0] cmd_address;
  logic cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid;
  logic cmd_ready = 1'b0;
  logic [7:0] data_tdata;
  logic data_tvalid, data_tlast;
  logic data_tready = 1'b0;
  logic [7:0] rx_tdata = '0;
  logic rx_tvalid = 1'b0;
  logic rx_tready;
  logic i2c_busy = 1'b0;

  always #5 clk = ~clk;

  i2c_reg_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_dev(req_dev),
    .req_reg(req_reg), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cmd_address(cmd_address),
    .cmd_start(cmd_start), .cmd_read(cmd_read), .cmd_write(cmd_write),
    .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .data_tdata(data_tdata), .data_tvalid(data_tvalid),
    .data_tlast(data_tlast), .data_tready(data_tready), .rx_tdata(rx_tdata),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .i2c_busy(i2c_busy)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  wire [11:0] cpay = {cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop};
  wire [8:0] dpay = {data_tlast, data_tdata};
  bit bp_en = 0, rx_en = 1, rx_stray = 0, cgot = 0, dgot = 0;
  logic [7:0] rx_val = '0;
  int cw = 0, dw = 0, rxc = 0;
  logic [11:0] cmd_log[$], rsp_log[$];
  logic [8:0] data_log[$];
  int gnt_log[$];
  logic pcv = 0, pcr = 0, pdv = 0, pdr = 0;
  logic [11:0] pcp = '0;
  logic [8:0] pdp = '0;

  // slave model: logs accepted beats, applies backpressure, returns read data, checks AXI hold
  initial forever begin
    @(negedge clk);
    if (!rst && !(rsp_valid && rsp_err)) begin
      if (pcv && !pcr) chk("cmd_hold", {cmd_valid, cpay}, {1'b1, pcp});
      if (pdv && !pdr) chk("data_hold", {data_tvalid, dpay}, {1'b1, pdp});
    end
    pcv = cmd_valid; pcp = cpay; pdv = data_tvalid; pdp = dpay;
    if (rsp_valid) rsp_log.push_back({rsp_err, rsp_id, rsp_rdata});
    if (|req_ready) begin
      chk("ready_onehot", $countones(req_ready), 1);
      for (int i = 0; i < N; i++) if (req_ready[i]) gnt_log.push_back(i);
    end
    cmd_ready = 1'b0;
    if (cmd_valid) begin
      if (!cgot) begin cw = bp_en ? $urandom_range(1, 20) : 0; cgot = 1; end
      if (cw > 0) cw--;
      else begin
        cmd_ready = 1'b1; cgot = 0; cmd_log.push_back(cpay);
        if (cmd_read && rx_en) rxc = 3;
      end
    end
    data_tready = 1'b0;
    if (data_tvalid) begin
      if (!dgot) begin dw = bp_en ? $urandom_range(1, 20) : 0; dgot = 1; end
      if (dw > 0) dw--;
      else begin data_tready = 1'b1; dgot = 0; data_log.push_back(dpay); end
    end
    pcr = cmd_ready; pdr = data_tready;
    rx_tvalid = 1'b0;
    if (rx_stray) begin rx_tvalid = 1'b1; rx_tdata = 8'hAA; rx_stray = 0; end
    else if (rxc > 0) begin
      rxc--;
      if (rxc == 0) begin rx_tvalid = 1'b1; rx_tdata = rx_val; end
    end
  end

  task automatic do_req(input int c, input bit wr, input logic [6:0] dv, input logic [7:0] rg,
                        input logic [7:0] wd, input bit lat);
    int t = 0;
    req_write[c] = wr; req_dev[7*c +: 7] = dv; req_reg[8*c +: 8] = rg; req_wdata[8*c +: 8] = wd;
    req_valid[c] = 1'b1;
    do begin @(negedge clk); t++; end while (!req_ready[c] && t < 400);
    req_valid[c] = 1'b0;
    chk("req_ready_seen", req_ready[c], 1);
    if (lat) chk("req_ready_latency", t, 1);
    @(negedge clk);
    chk("cmd_valid_after_ready", cmd_valid, 1);
  endtask

  task automatic wait_rsp(input int cnt);
    int t = 0;
    while (rsp_log.size() < cnt && t < 300) begin @(negedge clk); t++; end
    chk("rsp_count", rsp_log.size(), cnt);
  endtask

  task automatic clr();
    cmd_log.delete(); data_log.delete(); rsp_log.delete(); gnt_log.delete();
  endtask

  function automatic logic [11:0] qc(input int k);
    return (cmd_log.size() > k) ? cmd_log[k] : 12'hFFF;
  endfunction
  function automatic logic [8:0] qd(input int k);
    return (data_log.size() > k) ? data_log[k] : 9'h1FF;
  endfunction
  function automatic logic [11:0] qr(input int k);
    return (rsp_log.size() > k) ? rsp_log[k] : 12'hFFF;
  endfunction

  typedef struct {
    int id; bit wr; logic [6:0] dev; logic [7:0] rg, wd, rx;
    int nc, nd; logic [11:0] c0, c1; logic [8:0] d0, d1; logic [11:0] rsp;
  } vec_t;
  vec_t tv[4];

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int cyc, t;
    logic seen;
    tv[0] = '{0, 1, 7'h5A, 8'h80, 8'h63, 8'h00, 1, 2, 12'hB53, 12'h000, 9'h080, 9'h163, 12'h000};
    tv[1] = '{1, 0, 7'h5A, 8'h00, 8'h00, 8'h05, 2, 1, 12'hB54, 12'hB59, 9'h100, 9'h000, 12'h105};
    tv[2] = '{0, 0, 7'h1B, 8'h5D, 8'h00, 8'hC3, 2, 1, 12'h374, 12'h379, 9'h15D, 9'h000, 12'h0C3};
    tv[3] = '{1, 1, 7'h7F, 8'hFF, 8'h00, 8'h00, 1, 2, 12'hFF3, 12'h000, 9'h0FF, 9'h100, 12'h100};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, cmd_valid, cpay,
        data_tvalid, dpay, rx_tready}, 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clr();
      rx_stray = 1; repeat (2) @(negedge clk);
      rx_val = tv[i].rx;
      do_req(tv[i].id, tv[i].wr, tv[i].dev, tv[i].rg, tv[i].wd, 1);
      wait_rsp(1);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_cmd_beats", i), cmd_log.size(), tv[i].nc);
      chk($sformatf("v%0d_cmd0", i), qc(0), tv[i].c0);
      if (tv[i].nc == 2) chk($sformatf("v%0d_cmd1", i), qc(1), tv[i].c1);
      chk($sformatf("v%0d_data_beats", i), data_log.size(), tv[i].nd);
      chk($sformatf("v%0d_data0", i), qd(0), tv[i].d0);
      if (tv[i].nd == 2) chk($sformatf("v%0d_data1", i), qd(1), tv[i].d1);
      chk($sformatf("v%0d_rsp", i), qr(0), tv[i].rsp);
    end
    clr(); bp_en = 1;
    do_req(1, 1, 7'h2C, 8'h11, 8'hEE, 1);
    wait_rsp(1);
    repeat (2) @(negedge clk);
    bp_en = 0;
    chk("bp_cmd_beats", cmd_log.size(), 1);
    chk("bp_cmd0", qc(0), 12'h593);
    chk("bp_data_beats", data_log.size(), 2);
    chk("bp_data0", qd(0), 9'h011);
    chk("bp_data1", qd(1), 9'h1EE);
    chk("bp_rsp", qr(0), 12'h100);
    clr();
    fork
      for (int k = 0; k < 3; k++) do_req(0, 1, 7'h10, 8'h01, 8'(k), 0);
      for (int k = 0; k < 3; k++) do_req(1, 1, 7'h11, 8'h02, 8'(k), 0);
    join
    wait_rsp(6);
    chk("fair_grants", gnt_log.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("fair_grant%0d", k), (gnt_log.size() > k) ? gnt_log[k] : -1, k % 2);
      chk($sformatf("fair_rsp_id%0d", k), qr(k), {1'b0, 3'(k % 2), 8'h00});
    end
    repeat (2) @(negedge clk);
    clr(); i2c_busy = 1'b1; rx_en = 0;
    do_req(0, 0, 7'h5A, 8'h00, 8'h00, 1);
    cyc = 1;
    while (!rsp_valid && cyc < 200) begin @(negedge clk); cyc++; end
    chk("timeout_cycle", cyc, 99);
    chk("timeout_rsp", {rsp_valid, rsp_err, rsp_id, rsp_rdata}, {1'b1, 1'b1, 3'd0, 8'd0});
    chk("timeout_valids", {cmd_valid, data_tvalid}, 0);
    req_write[1] = 1'b1; req_dev[13:7] = 7'h22; req_reg[15:8] = 8'h33; req_wdata[15:8] = 8'h44;
    req_valid[1] = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen = seen | (|req_ready); end
    chk("drain_holds_while_busy", seen, 0);
    chk("timeout_rsp_once", rsp_log.size(), 1);
    i2c_busy = 1'b0; t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[1] && t < 50);
    req_valid[1] = 1'b0;
    chk("drain_release", t, 2);
    wait_rsp(2);
    chk("after_drain_rsp", qr(1), 12'h100);
    repeat (2) @(negedge clk);
    clr();
    do_req(0, 0, 7'h5A, 8'h00, 8'h00, 1);
    t = 0;
    while (cmd_log.size() < 2 && t < 100) begin @(negedge clk); t++; end
    chk("rst_read_cmds", cmd_log.size(), 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midread_reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, cmd_valid, cpay,
        data_tvalid, dpay, rx_tready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midread_no_rsp", rsp_log.size(), 0);
    clr(); rx_en = 1;
    fork
      do_req(0, 1, 7'h30, 8'h01, 8'h02, 0);
      do_req(1, 1, 7'h31, 8'h03, 8'h04, 0);
    join
    wait_rsp(2);
    chk("post_reset_grant0", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    chk("post_reset_grant1", (gnt_log.size() > 1) ? gnt_log[1] : -1, 1);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_reg_arbiter.md
# i2c_reg_arbiter

Round-robin arbiter and transaction sequencer that shares one `i2c_master` command/data AXI-stream interface between `NUM_REQ` register-access clients, e.g. the MPR121 touch poller and a configuration loader. Each client issues single-byte register writes or reads (device address, register address, write data). The block expands each request into the correct `i2c_master` command/data beats and returns the response to the originating client. It sits between the clients and `i2c_master`, and is the only driver of `i2c_master`'s `s_axis_cmd_*` and `s_axis_data_*` inputs.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of clients, 1–8.
- `TIMEOUT_CYCLES`, default 27_000_000: per-transaction watchdog, in `clk` cycles.

Ports. One clock; reset is synchronous and active-high: `clk` and `rst`.
- `clk`  in  1  system clock (27 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  client i requests a transaction.
- `req_write`  in  NUM_REQ  1 = register write, 0 = register read.
- `req_dev`  in  7*NUM_REQ  7-bit device address; slice i is `[7i+6:7i]`.
- `req_reg`  in  8*NUM_REQ  register address.
- `req_wdata`  in  8*NUM_REQ  write data.
- `req_ready`  out  NUM_REQ  one-cycle acceptance pulse to the granted client.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_id`  out  3  index of the client that completed.
- `rsp_rdata`  out  8  read data; 0 for writes.
- `rsp_err`  out  1  transaction aborted by the watchdog.
- `cmd_address`, `cmd_start`, `cmd_read`, `cmd_write`, `cmd_write_multiple`, `cmd_stop`, `cmd_valid`  out  7/1/1/1/1/1/1  connect to `i2c_master` `s_axis_cmd_*`.
- `cmd_ready`  in  1  from `i2c_master`.
- `data_tdata`, `data_tvalid`, `data_tlast`  out  8/1/1  connect to `s_axis_data_*`.
- `data_tready`  in  1  from `i2c_master`.
- `rx_tdata`, `rx_tvalid`  in  8/1  from `m_axis_data_*`.
- `rx_tready`  out  1  constant 1.
- `i2c_busy`  in  1  `i2c_master` busy.

## Operation
- All outputs are registered. Reset values are 0 for every output except `rx_tready`, which is 1. Reset forces IDLE, sets the round-robin pointer to 0 and clears the watchdog. Reset asserted mid-transaction abandons the transaction; no `rsp_valid` is issued.
- Arbitration happens in IDLE only, when any `req_valid` is set. The grant goes to the first requesting client at or after `(last_grant+1) mod NUM_REQ`. The block pulses `req_ready[g]` and latches that client's `req_dev`, `req_reg`, `req_wdata` and `req_write`. Clients hold their request until `req_ready` is seen.
- AXI rule: every valid the block drives holds, with payload unchanged, until the cycle in which its ready is high. The valid then drops in the following cycle unless the next beat is presented immediately.
- Write sequence: CMD_W → DREG → DVAL → DONE.
  - CMD_W presents `cmd_start=1`, `cmd_write_multiple=1`, `cmd_stop=1`.
  - DREG presents `data_tdata=reg`, `data_tlast=0`.
  - DVAL presents `data_tdata=wdata`, `data_tlast=1`.
- Read sequence: CMD_W → DREG → CMD_R → WAIT_RX → DONE.
  - CMD_W presents `cmd_start=1`, `cmd_write=1`, `cmd_stop=0`.
  - DREG presents `reg` with `data_tlast=1`.
  - CMD_R presents `cmd_start=1`, `cmd_read=1`, `cmd_stop=1`.
  - WAIT_RX captures `rx_tdata` on `rx_tvalid`.
- `rx_tvalid` outside WAIT_RX is discarded.
- DONE pulses `rsp_valid` for one cycle with `rsp_id`, `rsp_rdata` and `rsp_err=0`. It then waits for `i2c_busy==0` before returning to IDLE. `rsp_id`, `rsp_rdata` and `rsp_err` hold until the next `rsp_valid`.
- Watchdog: counts from acceptance and clears on return to IDLE. At `TIMEOUT_CYCLES-1` in any non-IDLE state other than DONE, the block:
  - drops all valids;
  - pulses `rsp_valid` with `rsp_err=1` and `rsp_rdata=0`;
  - enters DRAIN, which waits for `i2c_busy==0` and then goes to IDLE.

## Timing
- `req_ready` asserts 1 cycle after `req_valid` is first seen in IDLE.
- `cmd_valid` for CMD_W asserts in the cycle after `req_ready`.
- Minimum back-to-back overhead is 1 idle cycle between `rsp_valid` and the next `req_ready`, given `i2c_busy` is already low.
- Simultaneous requests: exactly one `req_ready` bit is ever high.
- `last_grant` updates on acceptance. Rotation wraps from `NUM_REQ-1` to 0.
- The watchdog counter width is `$clog2(TIMEOUT_CYCLES)`.
- No response is issued for unaccepted requests.

## Test plan
- Write path: client 0 writes dev 0x5A, reg 0x80, data 0x63, with a slave model that ACKs.
  - Required: one cmd beat with start, write_multiple and stop all set; data beats 0x80 (tlast=0) then 0x63 (tlast=1).
  - Required: `rsp_valid` with `rsp_id=0`, `rsp_err=0`.
- Read path: client 1 reads dev 0x5A, reg 0x00; the model returns 0x05.
  - Required: cmd write without stop, data 0x00 with tlast=1, then cmd read with stop.
  - Required: `rsp_rdata=0x05`, `rsp_id=1`.
- Backpressure: hold `cmd_ready` and `data_tready` low for 20 random cycles per beat.
  - Required: valid and payload stay stable until ready.
  - Required: no beat is duplicated or lost.
- Fairness: both clients request continuously for 6 transactions.
  - Required: grants go 0,1,0,1,0,1.
  - Required: `req_ready` is never simultaneous.
- Timeout: with `TIMEOUT_CYCLES=100`, `rx_tvalid` is never asserted in a read.
  - Required: `rsp_valid` with `rsp_err=1` at cycle 99 after acceptance, `rsp_rdata=0`.
  - Required: IDLE is reached only after `i2c_busy` drops.
- Reset mid-read: assert `rst` during WAIT_RX.
  - Required: all outputs return to their reset values next cycle and no `rsp_valid` is issued.
  - Required: the next request is granted to client 0.
